// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared state encoding and requester indices for the data memory arbiter.
package data_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;
endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick favouring the requester that did not win last.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_idx
);
  always_comb begin
    o_valid = |i_req;
    o_idx   = &i_req ? ~i_last : i_req[1];
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sequencer giving two requesters serialised access to a single-port data memory.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MEM_SIZE = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);
  state_t r_state;
  logic r_sel, r_we, r_last;
  logic w_valid, w_idx, w_we, w_in_range;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  rr_arb2 u_arb (
    .i_req  ({m1_req, m0_req}),
    .i_last (r_last),
    .o_valid(w_valid),
    .o_idx  (w_idx)
  );

  always_comb begin
    w_we       = w_idx ? m1_we : m0_we;
    w_addr     = w_idx ? m1_addr : m0_addr;
    w_wdata    = w_idx ? m1_wdata : m0_wdata;
    w_in_range = w_addr < ADDR_W'(MEM_SIZE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_sel          <= REQ_CPU;
      r_we           <= 1'b0;
      r_last         <= REQ_DBG;
      m0_ack         <= 1'b0;
      m0_err         <= 1'b0;
      m0_rdata       <= '0;
      m1_ack         <= 1'b0;
      m1_err         <= 1'b0;
      m1_rdata       <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_valid) begin
          r_sel  <= w_idx;
          r_we   <= w_we;
          r_last <= w_idx;
          if (w_in_range) begin
            r_state     <= ACCESS;
            mem_address <= w_addr;
            mem_read    <= !w_we;
            mem_write   <= w_we;
            if (w_we) mem_write_data <= w_wdata;
          end else begin
            // out-of-range requests skip memory entirely and answer with an error
            r_state <= RESP;
            if (w_idx == REQ_DBG) begin
              m1_ack   <= 1'b1;
              m1_err   <= 1'b1;
              m1_rdata <= '0;
            end else begin
              m0_ack   <= 1'b1;
              m0_err   <= 1'b1;
              m0_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          r_state   <= RESP;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (r_sel == REQ_DBG) begin
            m1_ack   <= 1'b1;
            m1_err   <= 1'b0;
            m1_rdata <= r_we ? '0 : mem_read_data;
          end else begin
            m0_ack   <= 1'b1;
            m0_err   <= 1'b0;
            m0_rdata <= r_we ? '0 : mem_read_data;
          end
        end
        RESP: begin
          r_state <= IDLE;
          m0_ack  <= 1'b0;
          m0_err  <= 1'b0;
          m1_ack  <= 1'b0;
          m1_err  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port data memory.
- Requester 0 is the CPU load/store path; requester 1 is a debug/DMA loader.
- Serialises accesses, drives the memory strobes for exactly one cycle per access, registers read data and returns a one-cycle acknowledge.
- Rejects out-of-range word addresses without touching memory.

Parameters:
- DATA_W, 32, data width of memory and requesters.
- ADDR_W, 32, word-address width.
- MEM_SIZE, 64, number of memory words; valid addresses are 0..MEM_SIZE-1.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  requester 0 access request; held with fields stable until m0_ack.
- m0_we  input  1  requester 0: 1 = write, 0 = read.
- m0_addr  input  ADDR_W  requester 0 word address.
- m0_wdata  input  DATA_W  requester 0 write data.
- m0_ack  output  1  one-cycle completion pulse to requester 0.
- m0_err  output  1  valid with m0_ack; address out of range.
- m0_rdata  output  DATA_W  read data, valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as the m0 ports, for requester 1.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_address  output  ADDR_W  memory word address.
- mem_write_data  output  DATA_W  memory write data.
- mem_read_data  input  DATA_W  memory read data (combinational from address).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE, all acks/errs 0, mem_read/mem_write 0, mem_address/mem_write_data 0, m0_rdata/m1_rdata 0, last_grant = 1 (so requester 0 wins the first tie).
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples both req inputs.
  - If neither is high, stay in IDLE.
  - If one is high, grant it. If both are high, grant the requester != last_grant.
  - On grant: latch sel, we, addr, wdata; update last_grant := sel.
  - addr < MEM_SIZE -> ACCESS. addr >= MEM_SIZE -> RESP with err.
- ACCESS (exactly 1 cycle):
  - mem_address = latched addr.
  - mem_write = we; mem_write_data = wdata when we = 1.
  - mem_read = !we.
  - Only one strobe is ever high.
  - At the end of the cycle, capture mem_read_data into the selected rdata register (reads only). Next state RESP.
- RESP (exactly 1 cycle):
  - ack of the selected requester = 1; err = 1 only for an out-of-range access.
  - rdata = captured word for reads; 0 for writes and errors.
  - Strobes 0. Unselected requester's ack/rdata unchanged.
  - Next state IDLE, unconditionally.
- Latency, req-to-ack: 3 cycles for an in-range access (IDLE sample, ACCESS, RESP); 2 cycles for an out-of-range access.
- Throughput: one access per 3 cycles.
- Handshake:
  - A request is consumed by its ack.
  - Requester drops req at the edge ending the ack cycle, or keeps it high to issue a new request, which is sampled in the following IDLE.
  - req, we, addr, wdata changes while waiting are a protocol violation; the latched copy is used.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1.
- Starvation: none; worst-case wait is one other access.
- Reset mid-operation:
  - Next state is IDLE, strobes and acks 0 after that edge; a pending request is dropped without ack.
  - A write strobe visible during the cycle reset is asserted may already have written memory; this is not guaranteed against.
- Address compare is unsigned over the full ADDR_W. The memory never sees an address >= MEM_SIZE.

Decomposition:
- Shared package: state encoding constants (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2), requester index constants REQ_CPU = 0, REQ_DBG = 1.
- One natural sub-module: rr_arb2 (combinational 2-way round-robin pick from req[1:0] and last_grant, outputs grant_valid and grant_idx).
- The FSM and datapath stay in data_mem_arbiter.

Test Plan:
- Reset, then m0 write addr 5 data 0xDEADBEEF -> mem_write = 1 for one cycle with mem_address = 5; m0_ack 3 cycles after req; m0_err = 0; m1_ack stays 0.
- m1 read addr 5 after that write -> mem_read = 1 for one cycle; m1_ack with m1_rdata = 0xDEADBEEF, m1_err = 0.
- m0 and m1 both hold req high (reads of addrs 1 and 2) for 12 cycles -> grant order 0,1,0,1; acks every 3 cycles, alternating; each rdata matches its own address.
- m0 read addr 64 (MEM_SIZE) -> no mem_read/mem_write at any cycle; m0_ack 2 cycles after req with m0_err = 1, m0_rdata = 0.
- reset asserted in the ACCESS cycle of an m1 read -> next cycle state IDLE, strobes 0, no m1_ack; a new m1 request afterwards completes normally.
- Back-to-back m0 requests with req held through the ack -> second access starts in the IDLE right after RESP; no duplicate ack; wdata of the second request is written.
